// File: rtl/muldiv_pkg.sv
// Shared widths and state encoding for the MulDiv datapath.
// The divider consumes the full 2N-bit multiplier product as its dividend.
package muldiv_pkg;

    localparam int N    = 4;
    localparam int ITER = 2 * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// subtract the divisor when it fits, and emit the resulting quotient bit.
module div_step
    import muldiv_pkg::*;
#(
    parameter int N = muldiv_pkg::N
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N:0] shifted_s;
    logic [N:0] trial_s;
    logic       fits_s;

    // Trial subtraction; a set bit shifted out of rem_in always means the divisor fits
    always_comb begin
        shifted_s = {rem_in[N-1:0], bit_in};
        trial_s   = shifted_s - {1'b0, divisor};
        fits_s    = rem_in[N] | (shifted_s >= {1'b0, divisor});
        if (fits_s) begin
            rem_out = trial_s;
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted_s;
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per cycle, with valid/ready handshakes and divide-by-zero flag.
module div_seq
    import muldiv_pkg::*;
#(
    parameter int N = muldiv_pkg::N
) (
    input  logic           CLK,
    input  logic           RESETN,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int             ITER_C = 2 * N;
    localparam int             CW     = $clog2(ITER_C);
    localparam logic [CW-1:0]  LAST_C = CW'(ITER_C - 1);

    div_state_t      state_r;
    div_state_t      next_s;
    logic [CW-1:0]   count_r;
    logic [N:0]      rem_r;
    logic [2*N-1:0]  quo_r;
    logic [N-1:0]    dvs_r;
    logic            dbz_r;
    logic            accept_s;
    logic            zero_div_s;
    logic [N:0]      step_rem_s;
    logic            step_q_s;

    assign accept_s   = in_valid && (state_r == IDLE);
    assign zero_div_s = (divisor == {N{1'b0}});

    // The MSB of the quotient register is the next dividend bit to bring down
    div_step #(.N(N)) u_step (
        .rem_in  (rem_r),
        .bit_in  (quo_r[2*N-1]),
        .divisor (dvs_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // State register
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (zero_div_s) begin
                        next_s = DONE;
                    end else begin
                        next_s = RUN;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == LAST_C) begin
                    next_s = DONE;
                end else begin
                    next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_s = IDLE;
                end else begin
                    next_s = DONE;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one restoring step per RUN cycle
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            count_r <= {CW{1'b0}};
            rem_r   <= {(N+1){1'b0}};
            quo_r   <= {(2*N){1'b0}};
            dvs_r   <= {N{1'b0}};
            dbz_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        dvs_r   <= divisor;
                        count_r <= {CW{1'b0}};
                        if (zero_div_s) begin
                            quo_r <= {(2*N){1'b1}};
                            rem_r <= {1'b0, dividend[N-1:0]};
                            dbz_r <= 1'b1;
                        end else begin
                            quo_r <= dividend;
                            rem_r <= {(N+1){1'b0}};
                            dbz_r <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_r   <= step_rem_s;
                    quo_r   <= {quo_r[2*N-2:0], step_q_s};
                    count_r <= count_r + 1'b1;
                end
                DONE: begin
                    count_r <= count_r;
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready    = (state_r == IDLE);
    assign out_valid   = (state_r == DONE);
    assign quotient    = quo_r;
    assign remainder   = rem_r[N-1:0];
    assign div_by_zero = dbz_r;

endmodule
